matrix_frame_sequencer: RTL and testbench

- Upstream feeder for output_module: walks one matrix frame out of the frame buffer, one byte per channel per step, and issues new_image / new_column / next_data command pulses paced by tx_finish.
- Sits between the HDMI-side frame buffer (synchronous read port, 1-cycle latency) and output_module.
- Replaces the hand-written test FSM in the top level.

---
 rtl/matrix_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_matrix_frame_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer: walks one matrix frame out of the frame buffer one
// byte per channel per step. It issues new_image / new_column / next_data
// command pulses to output_module, paced by tx_finish.
// Optional build macro: MATRIX_SEQ_TEST_PATTERN_EN. When it is defined,
// test_pattern=1 loads a generated pattern instead of frame buffer data.
//
// Command handshake with output_module: a command is issued only while
// tx_finish=1. It is a single-cycle pulse. output_module acknowledges it by
// dropping tx_finish and signals completion by raising it again. data_in holds
// still from LOAD until that completion is seen.
module matrix_frame_sequencer #(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int SPI_SIZE         = 8,
    parameter int BYTES_PER_MATRIX = 384,
    parameter int COLUMN_BYTES     = 24,
    parameter int ACK_TIMEOUT      = 15
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  frame_start,
    output logic [$clog2(BYTES_PER_MATRIX)-1:0]   rd_addr,
    output logic                                  rd_en,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0]    rd_data,
    input  logic                                  test_pattern,
    output logic [SPI_SIZE-1:0]                   data_in [CHANNEL_NUMBER],
    output logic                                  new_image,
    output logic                                  new_column,
    output logic                                  next_data,
    input  logic                                  tx_finish,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  error
);
    localparam int AW = $clog2(BYTES_PER_MATRIX);
    localparam int CW = $clog2(COLUMN_BYTES);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int DW = CHANNEL_NUMBER * SPI_SIZE;

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, ISSUE, ACK, DONE_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   byte_idx_q, byte_idx_d;
    logic [CW-1:0]   col_q, col_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   data_q, data_d;
    logic            rd_en_q, rd_en_d;
    logic            new_image_q, new_image_d;
    logic            new_column_q, new_column_d;
    logic            next_data_q, next_data_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            error_q, error_d;

    logic            pat_sel;
    logic [DW-1:0]   pat_data;

`ifdef MATRIX_SEQ_TEST_PATTERN_EN
    assign pat_sel = test_pattern;

    // Light one channel per third of the frame: ch0, then ch1, then ch2.
    always_comb begin
        pat_data = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            if ((i == 0 && int'(byte_idx_q) < 128) ||
                (i == 1 && int'(byte_idx_q) >= 128 && int'(byte_idx_q) < 256) ||
                (i == 2 && int'(byte_idx_q) >= 256)) begin
                pat_data[i*SPI_SIZE +: SPI_SIZE] = '1;
            end
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
    assign pat_sel             = 1'b0;
    assign pat_data            = '0;
`endif

    // State register and registered outputs; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            col_q        <= '0;
            tmo_q        <= '0;
            data_q       <= '0;
            rd_en_q      <= 1'b0;
            new_image_q  <= 1'b0;
            new_column_q <= 1'b0;
            next_data_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            col_q        <= col_d;
            tmo_q        <= tmo_d;
            data_q       <= data_d;
            rd_en_q      <= rd_en_d;
            new_image_q  <= new_image_d;
            new_column_q <= new_column_d;
            next_data_q  <= next_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic. Pulses default low, so each one lasts a single cycle.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        col_d        = col_q;
        tmo_d        = tmo_q;
        data_d       = data_q;
        rd_en_d      = 1'b0;
        new_image_d  = 1'b0;
        new_column_d = 1'b0;
        next_data_d  = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        error_d      = error_q;
        case (state_q)
            IDLE: begin
                if (frame_start && tx_finish) begin
                    state_d    = FETCH;
                    byte_idx_d = '0;
                    col_d      = '0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    rd_en_d    = !pat_sel;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                data_d  = pat_sel ? pat_data : rd_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (tx_finish) begin
                    if (byte_idx_q == '0)   new_image_d  = 1'b1;
                    else if (col_q == '0)   new_column_d = 1'b1;
                    else                    next_data_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!tx_finish) begin
                    state_d = DONE_WAIT;
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    error_d      = 1'b1;
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE_WAIT: begin
                if (tx_finish) begin
                    if (byte_idx_q == AW'(BYTES_PER_MATRIX - 1)) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        col_d      = (col_q == CW'(COLUMN_BYTES - 1)) ? '0 : col_q + 1'b1;
                        rd_en_d    = !pat_sel;
                        state_d    = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr    = byte_idx_q;
    assign rd_en      = rd_en_q;
    assign new_image  = new_image_q;
    assign new_column = new_column_q;
    assign next_data  = next_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;

    for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_data_out
        assign data_in[g] = data_q[g*SPI_SIZE +: SPI_SIZE];
    end

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Directed testbench for matrix_frame_sequencer with an output_module
// responder, a RAM model holding addr[7:0] per channel, and a command log.
module tb_matrix_frame_sequencer;
    localparam int CH  = 3;
    localparam int SW  = 8;
    localparam int BPM = 384;
    localparam int CB  = 24;
    localparam int AW  = $clog2(BPM);
    localparam int W   = 2 + CH*SW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              test_pattern = 1'b0;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic [CH*SW-1:0]  rd_data = '0;
    logic [SW-1:0]     data_in [CH];
    logic              new_image, new_column, next_data;
    logic              tx_finish, busy, frame_done, error;

    logic resp_en   = 1'b1;
    logic tx_force  = 1'b1;
    logic resp_hold = 1'b0;
    logic tx_model  = 1'b1;
    assign tx_finish = resp_en ? tx_model : tx_force;

    logic [CH*SW-1:0] din_packed;
    assign din_packed = {data_in[2], data_in[1], data_in[0]};

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    matrix_frame_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .test_pattern (test_pattern),
        .data_in      (data_in),
        .new_image    (new_image),
        .new_column   (new_column),
        .next_data    (next_data),
        .tx_finish    (tx_finish),
        .busy         (busy),
        .frame_done   (frame_done),
        .error        (error)
    );

    // Frame buffer model: synchronous read, 1-cycle latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= {CH{rd_addr[7:0]}};
    end

    // output_module responder: tx_finish drops 2 cycles after a pulse, rises 10 later.
    int ph = 0;
    int rc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ph = 0; rc = 0; tx_model = 1'b1;
        end else begin
            case (ph)
                0: if ((new_image || new_column || next_data) && !resp_hold) begin
                    ph = 1; rc = 0;
                end
                1: begin
                    rc++;
                    if (rc == 2) begin tx_model = 1'b0; ph = 2; rc = 0; end
                end
                default: begin
                    rc++;
                    if (rc == 10) begin tx_model = 1'b1; ph = 0; end
                end
            endcase
        end
    end

    // Monitor: pulse counters and per-byte command/data log.
    int n_img = 0, n_col = 0, n_nxt = 0, n_done = 0, n_rd = 0, n_ovl = 0;
    int last_byte = -1;
    logic [1:0]       cmd_log  [BPM];
    logic [CH*SW-1:0] data_log [BPM];
    always @(negedge clk) begin
        if (int'(new_image) + int'(new_column) + int'(next_data) > 1) n_ovl++;
        if (new_image)       begin n_img++; last_byte = 0; end
        else if (new_column) begin n_col++; last_byte++; end
        else if (next_data)  begin n_nxt++; last_byte++; end
        if ((new_image || new_column || next_data) && last_byte >= 0 && last_byte < BPM) begin
            cmd_log[last_byte]  = new_image ? 2'd1 : (new_column ? 2'd2 : 2'd3);
            data_log[last_byte] = din_packed;
        end
        if (frame_done) n_done++;
        if (rd_en) n_rd++;
    end

    // Scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic pulse_start();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        #1;
    endtask

    task automatic wait_byte(input int n, input int budget);
        int k;
        k = 0;
        while (last_byte != n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check_eq($sformatf("reach_byte_%0d", n), last_byte, n);
    endtask

    task automatic wait_done(input int budget);
        int k, d0;
        k = 0; d0 = n_done;
        while (n_done == d0 && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check_eq("frame_done_seen", n_done - d0, 1);
    endtask

    int s_img, s_col, s_nxt, s_done, s_rd, k;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_cmds", {new_image, new_column, next_data}, 0);
        check_eq("rst_done_err", {frame_done, error}, 0);
        check_eq("rst_data", din_packed, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame with latency check
        s_img = n_img; s_col = n_col; s_nxt = n_nxt; s_done = n_done; s_rd = n_rd;
        pulse_start();
        check_eq("accept_busy", busy, 1);
        check_eq("fetch_rd_en", rd_en, 1);
        @(negedge clk); #1;
        check_eq("load_rd_en", rd_en, 0);
        @(negedge clk); #1;
        check_eq("lat2_new_image", new_image, 0);
        @(negedge clk); #1;
        check_eq("lat3_new_image", new_image, 1);
        check_eq("first_data", din_packed, 24'h000000);
        wait_done(10000);
        @(negedge clk); #1;
        check_eq("frame_img", n_img - s_img, 1);
        check_eq("frame_col", n_col - s_col, 15);
        check_eq("frame_nxt", n_nxt - s_nxt, 368);
        check_eq("frame_done_cnt", n_done - s_done, 1);
        check_eq("frame_rd_cnt", n_rd - s_rd, BPM);
        check_eq("frame_busy_end", busy, 0);
        check_eq("frame_error", error, 0);
        check_eq("byte25_data", data_log[25], 24'h191919);
        check_eq("byte24_cmd", cmd_log[24], 2);
        for (int i = 0; i < BPM; i++) begin
            logic [7:0] b;
            b = 8'(i);
            exp_q.push_back({((i == 0) ? 2'd1 : ((i % CB == 0) ? 2'd2 : 2'd3)), {CH{b}}});
        end
        for (int i = 0; i < BPM; i++) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check_eq($sformatf("cmd_%0d", i), cmd_log[i], e[W-1 -: 2]);
            check_eq($sformatf("data_%0d", i), data_log[i], e[CH*SW-1:0]);
        end

        // ACK timeout
        resp_hold = 1'b1;
        s_img = n_img; s_col = n_col; s_nxt = n_nxt; s_done = n_done;
        pulse_start();
        k = 0;
        while (n_img == s_img && k < 20) begin @(negedge clk); #1; k++; end
        check_eq("tmo_new_image", n_img - s_img, 1);
        k = 0;
        while (n_done == s_done && k < 40) begin @(negedge clk); #1; k++; end
        check_eq("tmo_cycles", k, 15);
        check_eq("tmo_error", error, 1);
        check_eq("tmo_busy", busy, 0);
        repeat (5) @(negedge clk);
        #1;
        check_eq("tmo_error_sticky", error, 1);
        check_eq("tmo_other_cmds", (n_col - s_col) + (n_nxt - s_nxt), 0);
        resp_hold = 1'b0;

        // Next frame clears error; frame_start while busy ignored; reset abort
        pulse_start();
        check_eq("restart_error_clr", error, 0);
        check_eq("restart_busy", busy, 1);
        wait_byte(100, 3000);
        s_img = n_img;
        pulse_start();
        wait_byte(200, 3000);
        check_eq("busy_start_ignored", n_img - s_img, 0);
        check_eq("byte101_cmd", cmd_log[101], 3);
        check_eq("byte120_cmd", cmd_log[120], 2);
        check_eq("byte150_data", data_log[150], 24'h969696);
        rst_n = 1'b0;
        #1;
        check_eq("abort_cmds", {new_image, new_column, next_data}, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_data", din_packed, 0);
        check_eq("abort_rd", {rd_en, rd_addr}, 0);
        check_eq("abort_done_err", {frame_done, error}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s_img = n_img; s_col = n_col; s_nxt = n_nxt; s_done = n_done;
        repeat (50) @(negedge clk);
        #1;
        check_eq("post_abort_pulses", (n_img - s_img) + (n_col - s_col) + (n_nxt - s_nxt), 0);
        check_eq("post_abort_done", n_done - s_done, 0);
        check_eq("post_abort_busy", busy, 0);

        // frame_start while tx_finish=0 is ignored
        resp_en = 1'b0; tx_force = 1'b0;
        s_img = n_img; s_rd = n_rd;
        pulse_start();
        repeat (10) @(negedge clk);
        #1;
        check_eq("txlow_busy", busy, 0);
        check_eq("txlow_new_image", n_img - s_img, 0);
        check_eq("txlow_rd_en", n_rd - s_rd, 0);
        resp_en = 1'b1;
        repeat (2) @(negedge clk);

`ifdef MATRIX_SEQ_TEST_PATTERN_EN
        // Generated pattern frame
        test_pattern = 1'b1;
        s_rd = n_rd;
        pulse_start();
        wait_done(10000);
        check_eq("pat_byte0", data_log[0], 24'h0000FF);
        check_eq("pat_byte127", data_log[127], 24'h0000FF);
        check_eq("pat_byte128", data_log[128], 24'h00FF00);
        check_eq("pat_byte255", data_log[255], 24'h00FF00);
        check_eq("pat_byte256", data_log[256], 24'hFF0000);
        check_eq("pat_rd_en", n_rd - s_rd, 0);
        test_pattern = 1'b0;
`endif

        check_eq("no_overlap", n_ovl, 0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
